// File: rtl/vhdl_dut_counter_pkg.sv
// Shared definitions for the loadable up-counter: default width, reset value
// and the per-cycle operation encoding used by the next-state logic.
package vhdl_dut_counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Value cout takes on reset; widened/narrowed to the instance width by the user.
    localparam logic [DEFAULT_WIDTH-1:0] COUT_RESET = '0;

    // Operation selected for the coming edge once reset has been excluded.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_COUNT = 2'd1,
        OP_LOAD  = 2'd2
    } op_e;

    // Load takes precedence over count; with neither the counter holds.
    function automatic op_e decode_op(input logic load, input logic enable);
        if (load) begin
            return OP_LOAD;
        end else if (enable) begin
            return OP_COUNT;
        end
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/vhdl_dut_counter_if.sv
// Wrapper interface bundling the counter's data-path signals; the clock and
// reset are supplied from outside so several blocks can share them.
interface vhdl_dut_counter_if
    import vhdl_dut_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic clk,
    input logic reset
);

    logic             load;
    logic             enable;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] cout;

    modport dut (
        input  clk,
        input  reset,
        input  load,
        input  enable,
        input  data,
        output cout
    );

    modport drv (
        input  clk,
        input  reset,
        output load,
        output enable,
        output data,
        input  cout
    );

endinterface

// File: rtl/vhdl_dut_counter_props.sv
// Passive checker for the counter: one-cycle properties describing what cout
// must be after each edge given the controls sampled at that edge.
module vhdl_dut_counter_props
    import vhdl_dut_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic             clk,
    input logic             reset,
    input logic             load,
    input logic             enable,
    input logic [WIDTH-1:0] data,
    input logic [WIDTH-1:0] cout
);

    // Reset wins over everything, so this check stays live while reset is high.
    a_reset_clears : assert property (@(posedge clk)
        reset |=> (cout == WIDTH'(COUT_RESET)));

    // Load replaces the count with data and ignores enable.
    a_load_takes_data : assert property (@(posedge clk) disable iff (reset)
        load |=> (cout == $past(data)));

    // Count by one, wrapping naturally modulo 2^WIDTH.
    a_enable_increments : assert property (@(posedge clk) disable iff (reset)
        (!load && enable) |=> (cout == WIDTH'($past(cout) + 1'b1)));

    // All-ones rolls over to zero without stalling.
    a_wrap_to_zero : assert property (@(posedge clk) disable iff (reset)
        (!load && enable && (cout == {WIDTH{1'b1}})) |=> (cout == '0));

    // No request means the value is kept.
    a_idle_holds : assert property (@(posedge clk) disable iff (reset)
        (!load && !enable) |=> (cout == $past(cout)));

endmodule

// File: rtl/vhdl_dut_counter.sv
// Loadable, enableable up-counter with synchronous active-high reset.
// Priority at each edge: reset, then load, then enable, otherwise hold.
module vhdl_dut_counter
    import vhdl_dut_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] cout
);

    op_e              op;
    logic [WIDTH-1:0] cout_d;
    logic [WIDTH-1:0] cout_q;

    // Choose the next count from load/enable; reset is applied at the register.
    always_comb begin
        op     = decode_op(load, enable);
        cout_d = cout_q;
        case (op)
            OP_LOAD:  cout_d = data;
            OP_COUNT: cout_d = cout_q + 1'b1;
            default:  cout_d = cout_q;
        endcase
    end

    // Counter register with synchronous reset taking priority over the next value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cout_q <= WIDTH'(COUT_RESET);
        end else begin
            cout_q <= cout_d;
        end
    end

    assign cout = cout_q;

    vhdl_dut_counter_props #(
        .WIDTH (WIDTH)
    ) u_props (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .enable (enable),
        .data   (data),
        .cout   (cout_q)
    );

endmodule

// File: tb/tb_vhdl_dut_counter.sv
// Directed self-checking bench for vhdl_dut_counter, driving it through the
// wrapper interface and checking cout one time unit after each rising edge.
module tb_vhdl_dut_counter;

    localparam int W = 8;

    logic clk;
    logic reset;

    int checks;
    int errors;

    logic [W-1:0] expected;

    vhdl_dut_counter_if #(.WIDTH(W)) cnt_if (
        .clk   (clk),
        .reset (reset)
    );

    vhdl_dut_counter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (cnt_if.load),
        .enable (cnt_if.enable),
        .data   (cnt_if.data),
        .cout   (cnt_if.cout)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive controls, let one rising edge sample them, then step past the edge.
    task automatic applyStimulus(input logic r, input logic l, input logic e,
                                 input logic [W-1:0] d);
        reset         = r;
        cnt_if.load   = l;
        cnt_if.enable = e;
        cnt_if.data   = d;
        @(posedge clk);
        #1;
    endtask

    // Compare cout with the bench's expected value.
    task automatic checkOutput(input string tag, input logic [W-1:0] exp_val);
        checks++;
        assert (cnt_if.cout === exp_val)
        else begin
            errors++;
            $error("[TB] FAIL %s: cout=0x%02h expected=0x%02h", tag, cnt_if.cout, exp_val);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        logic [W-1:0] burst_end [5];
        burst_end[0] = 8'h31;
        burst_end[1] = 8'h4A;
        burst_end[2] = 8'h63;
        burst_end[3] = 8'h7C;
        burst_end[4] = 8'h95;

        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        cnt_if.load   = 1'b0;
        cnt_if.enable = 1'b0;
        cnt_if.data   = '0;

        // Reset for five cycles, then idle: zero and holding.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput("reset", 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h5A);
            checkOutput("unloaded_hold", 8'h00);
        end

        // Load 0xFF for four cycles, then hold.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
            checkOutput("load_ff", 8'hFF);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            checkOutput("load_hold", 8'hFF);
        end

        // Wrap from 0xFF and count 25 steps to 0x18.
        expected = 8'hFF;
        for (int i = 0; i < 25; i++) begin
            expected = expected + 8'h01;
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput(i == 0 ? "wrap" : "count", expected);
        end
        checkOutput("count_end", 8'h18);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            checkOutput("count_hold", 8'h18);
        end

        // Five bursts of 25 counts, each followed by five idle cycles.
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 25; i++) begin
                expected = expected + 8'h01;
                applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
                checkOutput("burst_count", expected);
            end
            checkOutput("burst_end", burst_end[b]);
            for (int i = 0; i < 5; i++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 8'hC3);
                checkOutput("burst_idle", burst_end[b]);
            end
        end

        // Load beats enable; reset beats load.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h10);
        checkOutput("load_over_enable", 8'h10);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF);
        checkOutput("reset_over_load", 8'h00);

        // Count up to 0x40, reset for one cycle while enabled, resume from 0.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3E);
        checkOutput("preload_3e", 8'h3E);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("count_3f", 8'h3F);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("count_40", 8'h40);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("midcount_reset", 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("resume_01", 8'h01);

        // A reset pulse entirely between edges must be ignored.
        reset = 1'b1;
        #3;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("glitch_reset_ignored", 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("count_after_glitch", 8'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
